// File: rtl/freq_count_pkg.sv
// Shared types and constants for the frequency counter with two-digit BCD output.
package freq_count_pkg;

    localparam int DECIMAL_BASE = 10;
    localparam int MAX_COUNT    = 99;
    localparam int EDGE_W       = 7;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        TENS  = 2'd1,
        UNITS = 2'd2
    } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a history flop; emits a one-cycle pulse
// for each rising edge of an asynchronous input.
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_edge
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/freq_count_bcd.sv
// Counts input rising edges over a gate window, converts the total to tens/units
// by repeated subtraction and presents the digits with a one-cycle load strobe.
module freq_count_bcd
    import freq_count_pkg::*;
#(
    parameter int UPDATE_PERIOD = 1200,
    parameter int PERIOD_W      = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       signal_in,
    output logic [3:0] ten_count,
    output logic [3:0] unit_count,
    output logic       load
);

    localparam logic [PERIOD_W-1:0] LAST_CYCLE = PERIOD_W'(UPDATE_PERIOD - 1);
    localparam logic [EDGE_W-1:0]   EDGE_MAX   = EDGE_W'(MAX_COUNT);
    localparam logic [EDGE_W-1:0]   EDGE_BASE  = EDGE_W'(DECIMAL_BASE);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PERIOD_W-1:0] r_period_cnt;
    logic [PERIOD_W-1:0] w_period_nxt;
    logic [EDGE_W-1:0]   r_edge_cnt;
    logic [EDGE_W-1:0]   w_edge_nxt;
    logic [3:0]          r_tens_acc;
    logic [3:0]          w_tens_nxt;
    logic [3:0]          r_ten_count;
    logic [3:0]          w_ten_nxt;
    logic [3:0]          r_unit_count;
    logic [3:0]          w_unit_nxt;
    logic                r_load;
    logic                w_load_nxt;
    logic                w_edge;

    edge_sync u_edge_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (signal_in),
        .o_edge  (w_edge)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= COUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold/default value before the case so no
        // path leaves it unassigned, which would otherwise infer a latch.
        w_state_nxt  = r_state;
        w_period_nxt = r_period_cnt;
        w_edge_nxt   = r_edge_cnt;
        w_tens_nxt   = r_tens_acc;
        w_ten_nxt    = r_ten_count;
        w_unit_nxt   = r_unit_count;
        w_load_nxt   = 1'b0;

        case (r_state)
            COUNT: begin
                w_period_nxt = r_period_cnt + 1'b1;
                if (w_edge && (r_edge_cnt < EDGE_MAX)) begin
                    w_edge_nxt = r_edge_cnt + 1'b1;
                end
                if (r_period_cnt == LAST_CYCLE) begin
                    w_state_nxt = TENS;
                end
            end
            TENS: begin
                if (r_edge_cnt >= EDGE_BASE) begin
                    w_edge_nxt = r_edge_cnt - EDGE_BASE;
                    w_tens_nxt = r_tens_acc + 4'd1;
                end else begin
                    w_state_nxt = UNITS;
                end
            end
            UNITS: begin
                // Remainder is below ten here, so its low nibble is the units digit.
                w_ten_nxt    = r_tens_acc;
                w_unit_nxt   = r_edge_cnt[3:0];
                w_load_nxt   = 1'b1;
                w_edge_nxt   = '0;
                w_tens_nxt   = '0;
                w_period_nxt = '0;
                w_state_nxt  = COUNT;
            end
            default: begin
                w_edge_nxt   = '0;
                w_tens_nxt   = '0;
                w_period_nxt = '0;
                w_state_nxt  = COUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_period_cnt <= '0;
            r_edge_cnt   <= '0;
            r_tens_acc   <= '0;
            r_ten_count  <= '0;
            r_unit_count <= '0;
            r_load       <= 1'b0;
        end else begin
            r_period_cnt <= w_period_nxt;
            r_edge_cnt   <= w_edge_nxt;
            r_tens_acc   <= w_tens_nxt;
            r_ten_count  <= w_ten_nxt;
            r_unit_count <= w_unit_nxt;
            r_load       <= w_load_nxt;
        end
    end

    assign ten_count  = r_ten_count;
    assign unit_count = r_unit_count;
    assign load       = r_load;

endmodule

// File: tb/tb_freq_count_bcd.sv
// Randomized bench: expected load times and digits come from a window-level model
// computed over the whole stimulus record of each reset-to-reset segment.
module tb_freq_count_bcd;

    localparam int U    = 240;
    localparam int PW   = 8;
    localparam int MAXC = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic       signal_in;
    logic [3:0] ten_count;
    logic [3:0] unit_count;
    logic       load;

    int total = 0;
    int bad   = 0;

    // samp[m+3] is the signal_in value sampled at clock edge m after reset release;
    // edges m <= 0 are reset edges and read as 0.
    bit samp [0:MAXC+3];
    int exp_at[$];
    int exp_ten[$];
    int exp_unit[$];

    freq_count_bcd #(
        .UPDATE_PERIOD (U),
        .PERIOD_W      (PW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .signal_in  (signal_in),
        .ten_count  (ten_count),
        .unit_count (unit_count),
        .load       (load)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // mode: 0 low, 1 high, 2 square wave, 3 sparse random, -1 random chunks.
    function automatic void build_stim(input int mode_sel, input int fixed_p, input int c);
        int i;
        i = 1;
        for (int k = 0; k < 4; k++) samp[k] = 1'b0;
        while (i <= c) begin
            int len;
            int mode;
            int p;
            int ph;
            len  = (mode_sel >= 0) ? c : int'($urandom_range(30, 400));
            mode = (mode_sel >= 0) ? mode_sel : int'($urandom_range(0, 3));
            p    = (fixed_p > 0) ? fixed_p : int'($urandom_range(2, 12));
            ph   = int'($urandom_range(0, p - 1));
            for (int j = 0; j < len && i <= c; j++) begin
                bit v;
                case (mode)
                    0:       v = 1'b0;
                    1:       v = 1'b1;
                    2:       v = (((i + ph) % p) < (p / 2)) ? 1'b1 : 1'b0;
                    default: v = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
                endcase
                samp[i + 3] = v;
                i++;
            end
        end
    endfunction

    // A window counting edges m0..m0+U-1 reports on edge m0+U+floor(N/10)+1,
    // after which the next window starts.
    function automatic void predict(input int c);
        int m0;
        exp_at.delete();
        exp_ten.delete();
        exp_unit.delete();
        m0 = 1;
        while (m0 + U - 1 <= c) begin
            int n;
            int at;
            n = 0;
            for (int m = m0; m < m0 + U; m++) begin
                if (samp[m + 1] && !samp[m]) n++;
            end
            if (n > 99) n = 99;
            at = m0 + U + n / 10 + 1;
            if (at > c) break;
            exp_at.push_back(at);
            exp_ten.push_back(n / 10);
            exp_unit.push_back(n % 10);
            m0 = at + 1;
        end
    endfunction

    task automatic run_segment(input int mode_sel, input int fixed_p, input int c);
        int held_ten;
        int held_unit;
        int nrst;
        build_stim(mode_sel, fixed_p, c);
        predict(c);
        nrst = int'($urandom_range(1, 3));
        for (int r = 0; r < nrst; r++) begin
            @(negedge clk);
            reset     = 1'b1;
            signal_in = samp[4];
            @(posedge clk);
            #1;
            check("rst_load", load, 1'b0);
            check("rst_ten", ten_count, 4'd0);
            check("rst_unit", unit_count, 4'd0);
        end
        held_ten  = 0;
        held_unit = 0;
        for (int m = 1; m <= c; m++) begin
            bit exp_load;
            @(negedge clk);
            reset     = 1'b0;
            signal_in = samp[m + 3];
            @(posedge clk);
            #1;
            exp_load = 1'b0;
            if (exp_at.size() > 0 && exp_at[0] == m) begin
                exp_load  = 1'b1;
                held_ten  = exp_ten[0];
                held_unit = exp_unit[0];
                void'(exp_at.pop_front());
                void'(exp_ten.pop_front());
                void'(exp_unit.pop_front());
            end
            check("load", load, exp_load);
            check("ten", ten_count, held_ten);
            check("unit", unit_count, held_unit);
        end
    endtask

    initial begin
        reset     = 1'b1;
        signal_in = 1'b0;
        run_segment(2, 2, 3 * U + 40);   // 120 edges/window: saturates to 9/9
        run_segment(1, 0, 3 * U);        // high at release: 0/1 then 0/0
        run_segment(2, 6, 2 * U + 10);   // ~40 edges; segment ends inside TENS
        run_segment(0, 0, 2 * U + 20);   // quiet input: 0/0 every U+2 cycles
        run_segment(2, 8, 3 * U);        // 30 edges/window: 3/0
        for (int s = 0; s < 5; s++) begin
            run_segment(-1, 0, int'($urandom_range(U, 4 * U)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
